// File: rtl/life_generation_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_generation_engine (with helper ones_counter)
// Purpose  : Sequential Game-of-Life stepper. Scans a WIDTH x HEIGHT board one
//            cell per clock, counts the live 8-neighbours of each cell with a
//            ones-counter, applies the B3/S23 rule and writes the result into
//            a shadow board. The shadow is committed atomically at end of scan.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            load_valid       - load load_data as current board (IDLE only)
//            load_data        - initial board, cell(r,c) = bit r*WIDTH+c
//            start            - request one generation step (IDLE only)
//            busy             - high while scanning or committing
//            done             - one-cycle pulse when a generation is committed
//            board_out        - committed board
//            gen_count        - generations committed since reset/load
// Options  : LIFE_TORUS_EN    - when defined, board edges wrap toroidally;
//                               otherwise off-board neighbours read as dead.
// Revision : 1.0 - initial release
// ============================================================================

module ones_counter #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic [N-1:0]     i_vec,
    output logic [CNT_W-1:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CNT_W'(i_vec[i]);
        end
    end
endmodule

module life_generation_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic [WIDTH*HEIGHT-1:0]   load_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   board_out,
    output logic [GEN_W-1:0]          gen_count
);
    localparam int c_cells = WIDTH * HEIGHT;
    localparam int c_rw    = $clog2(HEIGHT);
    localparam int c_cw    = $clog2(WIDTH);
    localparam logic [c_rw-1:0]    c_last_row = c_rw'(HEIGHT - 1);
    localparam logic [c_cw-1:0]    c_last_col = c_cw'(WIDTH - 1);
    localparam logic [c_cells-1:0] c_one      = c_cells'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [c_cells-1:0]   board_q,  board_d;
    logic [c_cells-1:0]   shadow_q, shadow_d;
    logic [GEN_W-1:0]     gen_q,    gen_d;
    logic [c_rw-1:0]      row_q,    row_d;
    logic [c_cw-1:0]      col_q,    col_d;
    logic                 done_q,   done_d;

    // Returns cell (r,c) of board b, forced dead when the position is off-board.
    function automatic logic f_cell(input logic [c_cells-1:0] b,
                                    input logic [c_rw-1:0]    r,
                                    input logic [c_cw-1:0]    c,
                                    input logic               ok);
        logic [c_cells-1:0] s;
        s = b >> (int'(r) * WIDTH + int'(c));
        return ok & s[0];
    endfunction

    // Neighbour row/column coordinates; wrap-around values are always
    // computed and the *_ok flags decide whether they are usable.
    logic [c_rw-1:0] w_row_m, w_row_p;
    logic [c_cw-1:0] w_col_m, w_col_p;
    logic            w_row_m_ok, w_row_p_ok, w_col_m_ok, w_col_p_ok;

    assign w_row_m = (row_q == '0)         ? c_last_row : row_q - c_rw'(1);
    assign w_row_p = (row_q == c_last_row) ? '0         : row_q + c_rw'(1);
    assign w_col_m = (col_q == '0)         ? c_last_col : col_q - c_cw'(1);
    assign w_col_p = (col_q == c_last_col) ? '0         : col_q + c_cw'(1);

`ifdef LIFE_TORUS_EN
    assign w_row_m_ok = 1'b1;
    assign w_row_p_ok = 1'b1;
    assign w_col_m_ok = 1'b1;
    assign w_col_p_ok = 1'b1;
`else
    assign w_row_m_ok = (row_q != '0);
    assign w_row_p_ok = (row_q != c_last_row);
    assign w_col_m_ok = (col_q != '0);
    assign w_col_p_ok = (col_q != c_last_col);
`endif

    // Neighbour vector, MSB first: NW, N, NE, W, E, SW, S, SE.
    logic [7:0] w_nbr;
    logic [3:0] w_count;
    logic       w_alive;
    logic       w_next;

    assign w_nbr = {
        f_cell(board_q, w_row_m, w_col_m, w_row_m_ok & w_col_m_ok),
        f_cell(board_q, w_row_m, col_q,   w_row_m_ok),
        f_cell(board_q, w_row_m, w_col_p, w_row_m_ok & w_col_p_ok),
        f_cell(board_q, row_q,   w_col_m, w_col_m_ok),
        f_cell(board_q, row_q,   w_col_p, w_col_p_ok),
        f_cell(board_q, w_row_p, w_col_m, w_row_p_ok & w_col_m_ok),
        f_cell(board_q, w_row_p, col_q,   w_row_p_ok),
        f_cell(board_q, w_row_p, w_col_p, w_row_p_ok & w_col_p_ok)
    };

    ones_counter #(
        .N     (8),
        .CNT_W (4)
    ) u_ones_counter (
        .i_vec   (w_nbr),
        .o_count (w_count)
    );

    assign w_alive = f_cell(board_q, row_q, col_q, 1'b1);
    assign w_next  = (w_count == 4'd3) | (w_alive & (w_count == 4'd2));

    int w_idx;
    assign w_idx = int'(row_q) * WIDTH + int'(col_q);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        shadow_d = shadow_q;
        gen_d    = gen_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Load wins over start; a start in the same cycle is dropped.
                if (load_valid) begin
                    board_d = load_data;
                    gen_d   = '0;
                end else if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                shadow_d = (shadow_q & ~(c_one << w_idx)) |
                           (c_cells'(w_next) << w_idx);
                if (col_q == c_last_col) begin
                    col_d = '0;
                    if (row_q == c_last_row) begin
                        row_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        row_d = row_q + c_rw'(1);
                    end
                end else begin
                    col_d = col_q + c_cw'(1);
                end
            end
            ST_COMMIT: begin
                board_d = shadow_q;
                gen_d   = gen_q + GEN_W'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            board_q  <= '0;
            shadow_q <= '0;
            gen_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            shadow_q <= shadow_d;
            gen_q    <= gen_d;
            row_q    <= row_d;
            col_q    <= col_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign board_out = board_q;
    assign gen_count = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_generation_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_generation_engine
// Purpose  : Directed self-checking bench for life_generation_engine (8x8,
//            GEN_W=2 so the generation counter wrap is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_generation_engine;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int GEN_W  = 2;
    localparam int c_lat  = WIDTH * HEIGHT + 1;

    localparam logic [63:0] c_blink_h = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] c_blink_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    localparam logic [63:0] c_block   = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] c_lone    = (64'd1 << 45);
    localparam logic [63:0] c_glider  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                        (64'd1 << 17) | (64'd1 << 18);
    localparam logic [63:0] c_glider4 = (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 25) |
                                        (64'd1 << 26) | (64'd1 << 27);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic [63:0]       load_data = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [63:0]       board_out;
    logic [GEN_W-1:0]  gen_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_generation_engine #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .GEN_W  (GEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .board_out  (board_out),
        .gen_count  (gen_count)
    );

    // Truncated-edge B3/S23 reference.
    function automatic logic [63:0] life_ref(input logic [63:0] b);
        logic [63:0] n;
        logic [63:0] t;
        int cnt;
        int rr;
        int cc;
        logic alive;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            t = b >> (rr * 8 + cc);
                            cnt += int'(t[0]);
                        end
                    end
                end
                t = b >> (r * 8 + c);
                alive = t[0];
                if (cnt == 3 || (alive && cnt == 2))
                    n = n | (64'd1 << (r * 8 + c));
            end
        end
        return n;
    endfunction

    task automatic do_load(input logic [63:0] data);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = data;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Pulses start, returns busy right after the start edge and the number of
    // edges from the start edge until done is seen (capped at 200).
    task automatic do_step(output int cyc, output logic busy0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (board_out !== 64'd0) begin errors++; $display("FAIL reset_board: got %h want 0", board_out); end
        checks++; if (gen_count !== 2'd0) begin errors++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        rst = 1'b0;
    endtask

    task automatic test_blinker();
        int cyc;
        logic b0;
        do_load(c_blink_h);
        do_step(cyc, b0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL blink_busy: got %b want 1", b0); end
        checks++; if (cyc != c_lat) begin errors++; $display("FAIL blink_latency: got %0d want %0d", cyc, c_lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blink_busy_at_done: got %b want 0", busy); end
        checks++; if (board_out !== c_blink_v) begin errors++; $display("FAIL blink_gen1: got %h want %h", board_out, c_blink_v); end
        checks++; if (gen_count !== 2'd1) begin errors++; $display("FAIL blink_gen1_count: got %0d want 1", gen_count); end
        do_step(cyc, b0);
        checks++; if (board_out !== c_blink_h) begin errors++; $display("FAIL blink_gen2: got %h want %h", board_out, c_blink_h); end
        checks++; if (gen_count !== 2'd2) begin errors++; $display("FAIL blink_gen2_count: got %0d want 2", gen_count); end
    endtask

    task automatic test_block_and_lone();
        int cyc;
        logic b0;
        do_load(c_block);
        for (int i = 0; i < 3; i++) begin
            do_step(cyc, b0);
            checks++; if (board_out !== c_block) begin errors++; $display("FAIL block_step%0d: got %h want %h", i, board_out, c_block); end
        end
        checks++; if (gen_count !== 2'd3) begin errors++; $display("FAIL block_count: got %0d want 3", gen_count); end
        do_load(c_lone);
        checks++; if (gen_count !== 2'd0) begin errors++; $display("FAIL load_clears_gen: got %0d want 0", gen_count); end
        do_step(cyc, b0);
        checks++; if (board_out !== 64'd0) begin errors++; $display("FAIL lone_dies: got %h want 0", board_out); end
    endtask

    task automatic test_glider();
        int cyc;
        logic b0;
        logic [63:0] exp_b;
        exp_b = c_glider;
        do_load(c_glider);
        for (int i = 0; i < 4; i++) begin
            exp_b = life_ref(exp_b);
            do_step(cyc, b0);
            checks++; if (board_out !== exp_b) begin errors++; $display("FAIL glider_step%0d: got %h want %h", i, board_out, exp_b); end
        end
        checks++; if (board_out !== c_glider4) begin errors++; $display("FAIL glider_shift: got %h want %h", board_out, c_glider4); end
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = c_block;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b want 0", busy); end
        checks++; if (board_out !== c_block) begin errors++; $display("FAIL prio_board: got %h want %h", board_out, c_block); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_start_dropped: got %b want 0", busy); end
    endtask

    task automatic test_scan_ignore();
        int first;
        int ndone;
        do_load(c_blink_h);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        first = -1;
        ndone = 0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            if (cyc == 10) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_data  = '1;
            end
            @(posedge clk);
            @(negedge clk);
            start      = 1'b0;
            load_valid = 1'b0;
            if (cyc == 10) begin
                checks++; if (board_out !== c_blink_h) begin errors++; $display("FAIL ignore_board_midscan: got %h want %h", board_out, c_blink_h); end
            end
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = cyc;
            end
        end
        checks++; if (first != c_lat) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", first, c_lat); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        checks++; if (board_out !== c_blink_v) begin errors++; $display("FAIL ignore_board: got %h want %h", board_out, c_blink_v); end
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        d1 = -1;
        d2 = -1;
        do_load(c_blink_h);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int cyc = 1; cyc <= 200 && d2 < 0; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2 = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (d1 != c_lat) begin errors++; $display("FAIL b2b_first: got %0d want %0d", d1, c_lat); end
        checks++; if (d2 != 2 * c_lat + 1) begin errors++; $display("FAIL b2b_second: got %0d want %0d", d2, 2 * c_lat + 1); end
        checks++; if (board_out !== c_blink_h) begin errors++; $display("FAIL b2b_board: got %h want %h", board_out, c_blink_h); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        logic b0;
        do_load(c_blink_h);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (board_out !== 64'd0) begin errors++; $display("FAIL midrst_board: got %h want 0", board_out); end
        checks++; if (gen_count !== 2'd0) begin errors++; $display("FAIL midrst_gen: got %0d want 0", gen_count); end
        do_load(c_blink_h);
        do_step(cyc, b0);
        checks++; if (cyc != c_lat) begin errors++; $display("FAIL midrst_relatency: got %0d want %0d", cyc, c_lat); end
        checks++; if (board_out !== c_blink_v) begin errors++; $display("FAIL midrst_reboard: got %h want %h", board_out, c_blink_v); end
    endtask

    task automatic test_gen_wrap();
        int cyc;
        logic b0;
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 0, 1};
        do_load(c_block);
        for (int i = 0; i < 5; i++) begin
            do_step(cyc, b0);
            checks++; if (gen_count !== GEN_W'(exp_seq[i])) begin errors++; $display("FAIL gen_wrap%0d: got %0d want %0d", i, gen_count, exp_seq[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block_and_lone();
        test_glider();
        test_load_priority();
        test_scan_ignore();
        test_back_to_back();
        test_mid_reset();
        test_gen_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
